ram_stream_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that drives our 64x16 dual-port RAM, which has a registered read address and two address ports. Port 1 (add1/we/DI) is the write port, and DO1 is left unused. Port 2 (add2 -> DO2) is the read port; the RAM's CLK1 and CLK2 are both tied to CLK. The block converts an upstream valid/ready word stream into RAM writes, then prefetches through the RAM's one-cycle read latency into a 2-entry output buffer, so the downstream valid/ready stream runs at full throughput.

---
 rtl/ram_stream_fifo_ctrl_if.sv | 39 +++
 rtl/ram_stream_fifo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ram_stream_fifo_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_fifo_ctrl_if.sv
// ram_stream_fifo_ctrl_if
// Bundles the upstream stream, the downstream stream and the RAM port
// signals of the FIFO controller.
//   s_valid/s_ready/s_data : upstream word stream (into the FIFO)
//   m_valid/m_ready/m_data : downstream word stream (out of the FIFO)
//   level                  : total words held by the controller
//   ram_we/ram_wadd/ram_di : RAM write port (port 1)
//   ram_radd/ram_do        : RAM read port (port 2, registered address)
// The master modport is the controller's view; the slave modport is the
// view of the environment (stream endpoints plus RAM).
interface ram_stream_fifo_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  logic          ram_we;
  logic [AW-1:0] ram_wadd;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_radd;
  logic [DW-1:0] ram_do;

  modport master (
    input  s_valid, s_data, m_ready, ram_do,
    output s_ready, m_valid, m_data, level,
           ram_we, ram_wadd, ram_di, ram_radd
  );

  modport slave (
    output s_valid, s_data, m_ready, ram_do,
    input  s_ready, m_valid, m_data, level,
           ram_we, ram_wadd, ram_di, ram_radd
  );
endinterface

// File: rtl/ram_stream_fifo_ctrl.sv
// ram_stream_fifo_ctrl
// Single-clock FIFO controller for a 2**AW x DW dual-port RAM whose read
// address is registered. Upstream words are written straight into the RAM;
// words are prefetched through the one-cycle read latency into a 2-entry
// output buffer so the downstream stream sustains one word per cycle.
// Ports:
//   CLK : clock (also clocks both RAM ports)
//   RST : synchronous reset, active-high
//   bus : ram_stream_fifo_ctrl_if.master (streams, level, RAM port signals)

// Invariant checker: the reported level always equals the words held in
// the RAM, in flight and in the output buffer, and never exceeds 2**AW+2.
module ram_stream_fifo_ctrl_chk #(
  parameter int AW = 6
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic [AW+1:0] level_i,
  input logic [AW:0]   ram_cnt_i,
  input logic          pend_i,
  input logic [1:0]    out_cnt_i
);
  localparam logic [AW+1:0] LVL_MAX = (AW+2)'((1 << AW) + 2);

  logic [AW+1:0] sum_s;
  assign sum_s = {1'b0, ram_cnt_i} + {{(AW+1){1'b0}}, pend_i} + {{AW{1'b0}}, out_cnt_i};

  a_level_sum : assert property (@(posedge clk_i) disable iff (rst_i) level_i == sum_s);
  a_level_max : assert property (@(posedge clk_i) disable iff (rst_i) level_i <= LVL_MAX);
endmodule

module ram_stream_fifo_ctrl #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input logic                     CLK,
  input logic                     RST,
  ram_stream_fifo_ctrl_if.master  bus
);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          pend_q,    pend_d;
  logic [1:0]    out_cnt_q, out_cnt_d;
  logic [DW-1:0] buf0_q,    buf0_d;
  logic [DW-1:0] buf1_q,    buf1_d;
  logic          m_valid_q, m_valid_d;
  logic [AW+1:0] level_q,   level_d;

  logic          s_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          fetch_s;
  logic [2:0]    occ_s;
  logic [1:0]    kept_s;

  // ram_cnt reaches 2**AW exactly when its top bit is set.
  assign s_ready_s = !RST && !ram_cnt_q[AW];
  assign push_s    = bus.s_valid && s_ready_s;
  assign pop_s     = m_valid_q && bus.m_ready;

  // Buffer slots that will be occupied after this edge, ignoring a new fetch;
  // a fetch is only issued if its word is guaranteed a slot when it lands.
  assign occ_s   = {1'b0, out_cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
  assign fetch_s = (ram_cnt_q != {(AW+1){1'b0}}) && (occ_s < 3'd2);

  // Entries left in the output buffer after this edge's pop.
  assign kept_s = out_cnt_q - {1'b0, pop_s};

  // Next-state logic for pointers, counters and the output buffer.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    pend_d    = fetch_s;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (fetch_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, fetch_s})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    // Shift only when a second entry exists, so m_data keeps its last
    // value once the buffer empties.
    if (pop_s && (out_cnt_q == 2'd2)) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end

    // The word fetched last edge lands at the tail, after the pop.
    if (pend_q) begin
      case (kept_s)
        2'd0:    buf0_d = bus.ram_do;
        2'd1:    buf1_d = bus.ram_do;
        default: buf1_d = buf1_q;
      endcase
    end else begin
      buf1_d = buf1_q;
    end

    out_cnt_d = kept_s + {1'b0, pend_q};
    m_valid_d = (out_cnt_d != 2'd0);
    level_d   = {1'b0, ram_cnt_d} + {{(AW+1){1'b0}}, pend_d} + {{AW{1'b0}}, out_cnt_d};
  end

  // State register with synchronous reset; RAM contents are left as-is.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      ram_cnt_q <= {(AW+1){1'b0}};
      pend_q    <= 1'b0;
      out_cnt_q <= 2'd0;
      buf0_q    <= {DW{1'b0}};
      buf1_q    <= {DW{1'b0}};
      m_valid_q <= 1'b0;
      level_q   <= {(AW+2){1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      pend_q    <= pend_d;
      out_cnt_q <= out_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      m_valid_q <= m_valid_d;
      level_q   <= level_d;
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = buf0_q;
  assign bus.level    = level_q;
  assign bus.ram_we   = push_s;
  assign bus.ram_wadd = wr_ptr_q;
  assign bus.ram_di   = bus.s_data;
  assign bus.ram_radd = rd_ptr_q;

  ram_stream_fifo_ctrl_chk #(.AW(AW)) u_chk (
    .clk_i     (CLK),
    .rst_i     (RST),
    .level_i   (level_q),
    .ram_cnt_i (ram_cnt_q),
    .pend_i    (pend_q),
    .out_cnt_i (out_cnt_q)
  );
endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// tb_ram_stream_fifo_ctrl
// Directed bench for ram_stream_fifo_ctrl with a behavioural 64x16 RAM
// (registered read address) attached to the controller's RAM ports.
module tb_ram_stream_fifo_ctrl;
  logic CLK;
  logic RST;

  ram_stream_fifo_ctrl_if #(.DW(16), .AW(6)) bus ();

  ram_stream_fifo_ctrl #(.DW(16), .AW(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // RAM model: port 1 write, port 2 read through a registered address.
  logic [15:0] mem [0:63];
  logic [5:0]  radd_q;
  always @(posedge CLK) begin
    if (bus.ram_we) mem[bus.ram_wadd] <= bus.ram_di;
    radd_q <= bus.ram_radd;
  end
  assign bus.ram_do = mem[radd_q];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] q[$];

  initial begin
    int acc, pushes, pops, wraps, first, last, seq;
    bit did_rst, push, pop;
    logic [15:0] wdata;

    for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
    radd_q = 6'd0;

    // Reset held 3 cycles with s_valid high.
    RST = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    bus.m_ready = 1'b0;
    repeat (3) begin
      step();
      check("rst_we",     32'(bus.ram_we),  32'd0);
      check("rst_sready", 32'(bus.s_ready), 32'd0);
      check("rst_mvalid", 32'(bus.m_valid), 32'd0);
      check("rst_level",  32'(bus.level),   32'd0);
    end
    RST = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check("rel_sready", 32'(bus.s_ready), 32'd1);

    // Single word, latency and pop.
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hA5A5;
    bus.m_ready = 1'b1;
    #1;
    check("sw_we",   32'(bus.ram_we),   32'd1);
    check("sw_wadd", 32'(bus.ram_wadd), 32'd0);
    step();
    bus.s_valid = 1'b0;
    #1;
    check("sw_lvl_e0",  32'(bus.level),    32'd1);
    check("sw_radd_e0", 32'(bus.ram_radd), 32'd0);
    check("sw_mv_e0",   32'(bus.m_valid),  32'd0);
    step();
    check("sw_radd_e1", 32'(bus.ram_radd), 32'd1);
    check("sw_mv_e1",   32'(bus.m_valid),  32'd0);
    step();
    check("sw_mv_e2",   32'(bus.m_valid),  32'd1);
    check("sw_md_e2",   32'(bus.m_data),   32'h0000A5A5);
    step();
    check("sw_mv_e3",   32'(bus.m_valid),  32'd0);
    check("sw_lvl_e3",  32'(bus.level),    32'd0);
    check("sw_md_hold", 32'(bus.m_data),   32'h0000A5A5);

    // Fill with the sink stalled.
    bus.m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 66; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(i);
      #1;
      if (bus.ram_we) acc++;
      step();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0042;
    #1;
    check("fill_acc",    32'(acc),         32'd66);
    check("fill_sready", 32'(bus.s_ready), 32'd0);
    check("fill_we",     32'(bus.ram_we),  32'd0);
    check("fill_level",  32'(bus.level),   32'd66);
    check("fill_mvalid", 32'(bus.m_valid), 32'd1);
    check("fill_mdata",  32'(bus.m_data),  32'd0);
    step();
    check("full_level",  32'(bus.level),   32'd66);
    check("full_mdata",  32'(bus.m_data),  32'd0);

    // Drain with the sink always ready.
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 66; i++) begin
      #1;
      check("drain_word", {15'd0, bus.m_valid, bus.m_data}, {15'd0, 1'b1, 16'(i)});
      step();
      if (i == 0) check("drain_sready", 32'(bus.s_ready), 32'd1);
    end
    #1;
    check("drain_mvalid", 32'(bus.m_valid), 32'd0);
    check("drain_level",  32'(bus.level),   32'd0);

    // Wrap and throughput: 200-word counter stream.
    pushes = 0; pops = 0; wraps = 0; first = -1; last = -1;
    for (int c = 0; c < 215; c++) begin
      bus.s_valid = (pushes < 200);
      bus.s_data  = 16'h1000 + 16'(pushes);
      bus.m_ready = 1'b1;
      #1;
      if (bus.ram_we) begin
        if (bus.ram_wadd == 6'd63) wraps++;
        pushes++;
      end
      if (bus.m_valid) begin
        check("tp_data", 32'(bus.m_data), 32'h1000 + 32'(pops));
        if (first < 0) first = c;
        last = c;
        pops++;
      end
      step();
    end
    check("tp_pops",  32'(pops),  32'd200);
    check("tp_first", 32'(first), 32'd3);
    check("tp_last",  32'(last),  32'd202);
    check("tp_wraps", 32'(wraps), 32'd3);

    // Random backpressure with a reset after 40 pushes.
    q.delete();
    pushes = 0; seq = 0; did_rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pushes == 40 && !did_rst) begin
        RST = 1'b1;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b0;
        step();
        step();
        RST = 1'b0;
        bus.s_valid = 1'b0;
        q.delete();
        did_rst = 1'b1;
        seq = 0;
        #1;
        check("rr_level",  32'(bus.level),   32'd0);
        check("rr_mvalid", 32'(bus.m_valid), 32'd0);
      end else begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.m_ready = 1'($urandom_range(0, 1));
        wdata = (did_rst ? 16'h3000 : 16'h2000) + 16'(seq);
        bus.s_data = wdata;
        #1;
        push = bus.ram_we;
        pop  = bus.m_valid && bus.m_ready;
        if (bus.m_valid) begin
          if (q.size() != 0) check("rnd_head", 32'(bus.m_data), 32'(q[0]));
          else check("rnd_spurious", 32'(bus.m_valid), 32'd0);
        end
        step();
        if (push) begin
          q.push_back(wdata);
          seq++;
          pushes++;
        end
        if (pop && q.size() != 0) void'(q.pop_front());
        check("rnd_level", 32'(bus.level), 32'(q.size()));
      end
    end

    // Final drain of the post-reset stream.
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      #1;
      pop = bus.m_valid;
      if (bus.m_valid) check("fin_head", 32'(bus.m_data), 32'(q[0]));
      step();
      if (pop) void'(q.pop_front());
      check("fin_level", 32'(bus.level), 32'(q.size()));
    end
    #1;
    check("fin_empty",  32'(q.size()),    32'd0);
    check("fin_mvalid", 32'(bus.m_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
